// File: rtl/conv_window_ctrl_if.sv
// Pixel-side and window-side handshake bundle between the line-buffer bank,
// the window controller and the MAC array.
interface conv_window_ctrl_if #(
    parameter int unsigned DATA_RES     = 8,
    parameter int unsigned KERNEL_WIDTH = 3,
    parameter int unsigned NUM_LINES    = 4
);
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned ROW_W  = KERNEL_WIDTH * DATA_RES;

    logic                                pixel_valid_i;
    logic                                pixel_ready_o;
    logic [NUM_LINES-1:0]                line_wr_o;
    logic [ADDR_W-1:0]                   read_address_o;
    logic [NUM_LINES*ROW_W-1:0]          line_pixels_i;
    logic [KERNEL_WIDTH*ROW_W-1:0]       window_o;
    logic                                window_valid_o;
    logic                                window_ready_i;

    // Controller side
    modport master (
        input  pixel_valid_i, line_pixels_i, window_ready_i,
        output pixel_ready_o, line_wr_o, read_address_o, window_o, window_valid_o
    );

    // Source / buffer bank / sink side
    modport slave (
        output pixel_valid_i, line_pixels_i, window_ready_i,
        input  pixel_ready_o, line_wr_o, read_address_o, window_o, window_valid_o
    );
endinterface

// File: rtl/conv_window_ctrl.sv
// Line-buffer bank controller: round-robin line writes, KxK window assembly.
// Optional frame flush (frame_done_o, per-frame reset of line state) under CONV_WIN_FRAME_FLUSH_EN.
module conv_window_ctrl #(
    parameter int unsigned DATA_RES       = 8,
    parameter int unsigned KERNEL_WIDTH   = 3,
    parameter int unsigned NUM_LINES      = 4,
    parameter int unsigned MAX_LINE_WIDTH = 32
) (
    input  logic                              clk_i,
    input  logic                              resetn_i,
    input  logic [$clog2(MAX_LINE_WIDTH)-1:0] image_dimension,
`ifdef CONV_WIN_FRAME_FLUSH_EN
    output logic                              frame_done_o,
`endif
    conv_window_ctrl_if.master                bus
);
    localparam int unsigned DIM_W  = $clog2(MAX_LINE_WIDTH);
    localparam int unsigned LINE_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int unsigned FULL_W = $clog2(NUM_LINES + 1);
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned ROW_W  = KERNEL_WIDTH * DATA_RES;

    typedef enum logic [1:0] {ST_FILL, ST_READ, ST_FLUSH} state_e;

    state_e              r_state;
    state_e              w_next_state;
    logic [ADDR_W-1:0]   r_read_address;
    logic [ADDR_W-1:0]   w_next_addr;
    logic [DIM_W-1:0]    r_wr_col;
    logic [LINE_W-1:0]   r_wr_line;
    logic [LINE_W-1:0]   r_rd_line;
    logic [FULL_W-1:0]   r_lines_full;
    logic [FULL_W-1:0]   w_lines_full_nxt;

    logic                w_pixel_ready;
    logic                w_accept;
    logic                w_line_done;
    logic                w_set_done;
    logic                w_flush;
    logic                w_kw_fit;
    logic [DIM_W-1:0]    w_last_col;
    logic [DIM_W-1:0]    w_last_start;
    logic [ADDR_W-1:0]   w_last_addr;
    int unsigned         w_row_line;

    function automatic logic [LINE_W-1:0] f_next_line(input logic [LINE_W-1:0] line);
        return (line == LINE_W'(NUM_LINES - 1)) ? '0 : line + LINE_W'(1);
    endfunction

    assign w_last_col   = image_dimension - DIM_W'(1);
    assign w_last_start = image_dimension - DIM_W'(KERNEL_WIDTH);
    assign w_last_addr  = ADDR_W'(w_last_start);
    assign w_kw_fit     = (image_dimension >= DIM_W'(KERNEL_WIDTH));

`ifdef CONV_WIN_FRAME_FLUSH_EN
    logic [DIM_W-1:0] r_set_cnt;
    logic [DIM_W-1:0] r_wr_rows;

    // Once a whole frame is written, hold input off until the flush cycle
    assign w_pixel_ready = (r_lines_full != FULL_W'(NUM_LINES)) &&
                           (r_wr_rows != image_dimension) && (r_state != ST_FLUSH);
    assign frame_done_o  = (r_state == ST_FLUSH);
`else
    assign w_pixel_ready = (r_lines_full != FULL_W'(NUM_LINES));
`endif

    // Reset also blanks the line write strobe in the same cycle
    assign w_accept    = bus.pixel_valid_i & w_pixel_ready & resetn_i;
    assign w_line_done = w_accept && (r_wr_col == w_last_col);

    assign bus.pixel_ready_o  = w_pixel_ready;
    assign bus.line_wr_o      = w_accept ? (NUM_LINES'(1) << r_wr_line) : '0;
    assign bus.read_address_o = r_read_address;
    assign bus.window_valid_o = (r_state == ST_READ);

    // Row r of the window comes from the r-th oldest line; oldest row lands in the MSBs
    always_comb begin
        bus.window_o = '0;
        w_row_line   = 0;
        for (int unsigned r = 0; r < KERNEL_WIDTH; r++) begin
            w_row_line = (32'(r_rd_line) + r) % NUM_LINES;
            bus.window_o[(KERNEL_WIDTH-1-r)*ROW_W +: ROW_W] =
                bus.line_pixels_i[w_row_line*ROW_W +: ROW_W];
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_next_addr      = r_read_address;
        w_flush          = 1'b0;
        w_set_done       = (r_state == ST_READ) && bus.window_ready_i &&
                           (r_read_address == w_last_addr);
        w_lines_full_nxt = FULL_W'(r_lines_full + FULL_W'(w_line_done) - FULL_W'(w_set_done));

        case (r_state)
            ST_FILL: begin
                if (w_kw_fit && (r_lines_full >= FULL_W'(KERNEL_WIDTH))) begin
                    w_next_state = ST_READ;
                    w_next_addr  = '0;
                end
            end
            ST_READ: begin
                if (bus.window_ready_i) begin
                    if (w_set_done) begin
                        w_next_addr = '0;
`ifdef CONV_WIN_FRAME_FLUSH_EN
                        if (r_set_cnt == w_last_start) w_next_state = ST_FLUSH;
                        else
`endif
                        if (w_lines_full_nxt >= FULL_W'(KERNEL_WIDTH)) w_next_state = ST_READ;
                        else                                           w_next_state = ST_FILL;
                    end else begin
                        w_next_addr = r_read_address + ADDR_W'(1);
                    end
                end
            end
            ST_FLUSH: begin
                w_flush      = 1'b1;
                w_next_state = ST_FILL;
            end
            default: w_next_state = ST_FILL;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state        <= ST_FILL;
            r_read_address <= '0;
        end else begin
            r_state        <= w_next_state;
            r_read_address <= w_next_addr;
        end
    end

    // Write pointer, read pointer and bank occupancy
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_wr_col     <= '0;
            r_wr_line    <= '0;
            r_rd_line    <= '0;
            r_lines_full <= '0;
        end else if (w_flush) begin
            r_wr_col     <= '0;
            r_wr_line    <= '0;
            r_rd_line    <= '0;
            r_lines_full <= '0;
        end else begin
            if (w_accept) r_wr_col <= w_line_done ? '0 : r_wr_col + DIM_W'(1);
            if (w_line_done) r_wr_line <= f_next_line(r_wr_line);
            if (w_set_done) r_rd_line <= f_next_line(r_rd_line);
            r_lines_full <= w_lines_full_nxt;
        end
    end

`ifdef CONV_WIN_FRAME_FLUSH_EN
    // Per-frame row-set and written-row counters
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_set_cnt <= '0;
            r_wr_rows <= '0;
        end else if (w_flush) begin
            r_set_cnt <= '0;
            r_wr_rows <= '0;
        end else begin
            if (w_set_done)  r_set_cnt <= r_set_cnt + DIM_W'(1);
            if (w_line_done) r_wr_rows <= r_wr_rows + DIM_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_conv_window_ctrl.sv
// Bench for conv_window_ctrl: line-buffer bank model, random valid/ready traffic,
// windows checked against an image-level reference (rows/columns of the pixel stream).
module tb_conv_window_ctrl;
    localparam int unsigned DR    = 8;
    localparam int unsigned KW    = 3;
    localparam int unsigned NL    = 4;
    localparam int unsigned MAXW  = 32;
    localparam int unsigned DIM_W = 5;
    localparam int unsigned ROW_W = KW * DR;
    localparam int unsigned WIN_W = KW * KW * DR;
`ifdef CONV_WIN_FRAME_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    logic             clk_i    = 1'b0;
    logic             resetn_i = 1'b0;
    logic [DIM_W-1:0] image_dimension = DIM_W'(5);
    logic [DR-1:0]    pix_data = '0;
    int               checks   = 0;
    int               failures = 0;
`ifdef CONV_WIN_FRAME_FLUSH_EN
    logic             frame_done;
`endif

    conv_window_ctrl_if #(.DATA_RES(DR), .KERNEL_WIDTH(KW), .NUM_LINES(NL)) u_if ();

    conv_window_ctrl #(
        .DATA_RES(DR), .KERNEL_WIDTH(KW), .NUM_LINES(NL), .MAX_LINE_WIDTH(MAXW)
    ) u_dut (
        .clk_i           (clk_i),
        .resetn_i        (resetn_i),
        .image_dimension (image_dimension),
`ifdef CONV_WIN_FRAME_FLUSH_EN
        .frame_done_o    (frame_done),
`endif
        .bus             (u_if)
    );

    always #5 clk_i = ~clk_i;

    // Line buffer bank: own write pointer per line, KW-pixel read port at read_address_o
    logic [DR-1:0] mem [NL][MAXW];
    int unsigned   wptr [NL];

    always @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            for (int n = 0; n < NL; n++) wptr[n] <= 0;
        end else begin
            for (int n = 0; n < NL; n++) begin
                if (u_if.line_wr_o[n]) begin
                    mem[n][wptr[n]] <= pix_data;
                    wptr[n] <= (wptr[n] + 1 >= 32'(image_dimension)) ? 0 : wptr[n] + 1;
                end
            end
        end
    end

    always_comb begin
        u_if.line_pixels_i = '0;
        for (int n = 0; n < NL; n++) begin
            for (int k = 0; k < KW; k++) begin
                u_if.line_pixels_i[n*ROW_W + (KW-1-k)*DR +: DR] =
                    mem[n][(32'(u_if.read_address_o) + k) % MAXW];
            end
        end
    end

    task automatic chk(input string tag, input logic [WIN_W-1:0] got, input logic [WIN_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One scenario: reset, stream nrows lines of length L, check every presented window.
    task automatic run(input int L, input int nrows, input bit seq, input int pv_pct,
                       input int rdy_pct, input int hold, input int abort_after);
        logic [DR-1:0]    img[$];
        logic [WIN_W-1:0] exp_q[$];
        int               exp_col[$];
        logic [WIN_W-1:0] w;
        logic [WIN_W-1:0] first_win = '0;
        bit               got_first = 1'b0;
        int total  = L * nrows;
        int frows  = FLUSH_EN ? L : nrows;
        int nfr    = FLUSH_EN ? (nrows + L - 1) / L : 1;
        int exp_acc, limit, line, nexp;
        int cyc = 0, nwin = 0, acc = 0, tail = -1;
        int set_cyc = -1, px_cyc = -1;
`ifdef CONV_WIN_FRAME_FLUSH_EN
        int nfd = 0;
        bit prev_fd = 1'b0;
`endif

        for (int i = 0; i < total; i++) img.push_back(seq ? DR'(i + 1) : DR'($urandom));
        if (L >= int'(KW)) begin
            for (int f = 0; f < nfr; f++)
                for (int s = 0; s + int'(KW) <= frows; s++) begin
                    if (f * frows + s + int'(KW) - 1 >= nrows) continue;
                    for (int c = 0; c + int'(KW) <= L; c++) begin
                        w = '0;
                        for (int r = 0; r < int'(KW); r++)
                            for (int k = 0; k < int'(KW); k++)
                                w = (w << DR) | WIN_W'(img[(f * frows + s + r) * L + c + k]);
                        exp_q.push_back(w);
                        exp_col.push_back(c);
                    end
                end
            exp_acc = total;
        end else begin
            exp_acc = (FLUSH_EN ? ((L < int'(NL)) ? L : int'(NL)) : int'(NL)) * L;
            if (exp_acc > total) exp_acc = total;
        end
        nexp  = exp_q.size();
        limit = 2000 + 20 * total;

        u_if.pixel_valid_i  = 1'b0;
        u_if.window_ready_i = 1'b0;
        resetn_i            = 1'b0;
        image_dimension     = DIM_W'(L);
        @(negedge clk_i); #1;
        chk("rst_wvalid", WIN_W'(u_if.window_valid_o), '0);
        chk("rst_prdy",   WIN_W'(u_if.pixel_ready_o), WIN_W'(1));
        chk("rst_linewr", WIN_W'(u_if.line_wr_o), '0);
        chk("rst_addr",   WIN_W'(u_if.read_address_o), '0);
`ifdef CONV_WIN_FRAME_FLUSH_EN
        chk("rst_fdone",  WIN_W'(frame_done), '0);
`endif
        @(negedge clk_i);
        resetn_i = 1'b1;

        while (cyc < limit && tail < 20) begin
            @(negedge clk_i);
            u_if.pixel_valid_i  = (acc < total) && ($urandom_range(99) < 32'(pv_pct));
            pix_data            = (acc < total) ? img[acc] : '0;
            u_if.window_ready_i = (cyc >= hold) && ($urandom_range(99) < 32'(rdy_pct));
            #1;

            if (abort_after > 0 && nwin == abort_after && u_if.window_valid_o) begin
                chk("abort_pre_addr", WIN_W'(u_if.read_address_o), WIN_W'(2));
                u_if.pixel_valid_i = 1'b1;
                resetn_i = 1'b0;
                #1;
                chk("abort_wvalid", WIN_W'(u_if.window_valid_o), '0);
                chk("abort_addr",   WIN_W'(u_if.read_address_o), '0);
                chk("abort_linewr", WIN_W'(u_if.line_wr_o), '0);
                chk("abort_prdy",   WIN_W'(u_if.pixel_ready_o), WIN_W'(1));
                return;
            end

            if (hold > 0 && cyc == hold) begin
                chk("hold_acc",    WIN_W'(acc), WIN_W'(NL * 32'(L)));
                chk("hold_prdy",   WIN_W'(u_if.pixel_ready_o), '0);
                chk("hold_wvalid", WIN_W'(u_if.window_valid_o), WIN_W'(1));
            end

            if (tail >= 0) begin
                chk("idle_wvalid", WIN_W'(u_if.window_valid_o), '0);
            end else if (u_if.window_valid_o) begin
                if (nwin < nexp) begin
                    chk("win",  u_if.window_o, exp_q[nwin]);
                    chk("addr", WIN_W'(u_if.read_address_o), WIN_W'(exp_col[nwin]));
                    if (!got_first) begin
                        first_win = u_if.window_o;
                        got_first = 1'b1;
                    end
                end else begin
                    chk("extra_win", WIN_W'(u_if.window_valid_o), '0);
                end
                if (u_if.window_ready_i) begin
                    if (nwin < nexp && exp_col[nwin] == L - int'(KW) && set_cyc < 0) set_cyc = cyc;
                    nwin++;
                end
            end

            if (u_if.pixel_valid_i && u_if.pixel_ready_o) begin
                line = FLUSH_EN ? ((acc / L) % L) % int'(NL) : (acc / L) % int'(NL);
                chk("line_wr", WIN_W'(u_if.line_wr_o), WIN_W'(1) << line);
                if (acc == int'(NL) * L && px_cyc < 0) px_cyc = cyc;
                acc++;
            end else begin
                chk("line_wr_idle", WIN_W'(u_if.line_wr_o), '0);
            end

`ifdef CONV_WIN_FRAME_FLUSH_EN
            if (frame_done) begin
                chk("fd_pulse", WIN_W'(prev_fd), '0);
                nfd++;
            end
            prev_fd = frame_done;
`endif
            cyc++;
            if (tail >= 0) tail++;
            else if (nwin == nexp && acc == exp_acc) tail = 0;
        end

        chk("done_win", WIN_W'(nwin), WIN_W'(nexp));
        chk("done_acc", WIN_W'(acc), WIN_W'(exp_acc));
        if (seq && L == 5 && nrows >= 3)
            chk("first_win", first_win, 72'h010203060708_0B0C0D);
        if (hold > 0)
            chk("px21_lat", WIN_W'(px_cyc), WIN_W'(set_cyc + 1));
`ifdef CONV_WIN_FRAME_FLUSH_EN
        chk("frames", WIN_W'(nfd), WIN_W'((L >= int'(KW)) ? nrows / L : 0));
`endif
    endtask

    initial begin
        int L, nr;
        u_if.pixel_valid_i  = 1'b0;
        u_if.window_ready_i = 1'b0;
        run(5, 3, 1'b1, 100, 100, 0, 0);
        run(5, 5, 1'b1, 100, 100, 60, 0);
        run(5, 5, 1'b0, 80, 40, 0, 0);
        run(5, 5, 1'b0, 100, 100, 0, 2);
        run(5, 4, 1'b1, 100, 100, 0, 0);
        run(5, 10, 1'b0, 100, 100, 0, 0);
        for (int i = 0; i < 6; i++) begin
            L  = int'($urandom_range(3, 12));
            nr = FLUSH_EN ? L * int'($urandom_range(1, 2)) : int'($urandom_range(3, 10));
            run(L, nr, 1'b0, int'($urandom_range(50, 100)), int'($urandom_range(30, 100)), 0, 0);
        end
        run(2, 6, 1'b0, 100, 100, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
